alu_rs: RTL and testbench

Reservation station for the integer ALU in the out-of-order RISC-V core. It sits directly upstream of the combinational ALU. It accepts decoded integer ops from dispatch and holds them until both operands are ready. It snoops the common data bus (CDB) for pending operands, and each cycle issues at most one ready entry as registered LV/RV/Op/ALU_ready inputs to the ALU, together with the destination ROB tag for the CDB arbiter.

---
 rtl/alu_rs_pkg.sv | 27 ++
 rtl/alu_rs_if.sv | 51 +++++
 rtl/alu_rs_select.sv | 24 ++
 rtl/alu_rs.sv | 140 ++++++++++++++
 tb/tb_alu_rs.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants for the integer ALU reservation station: ALU op
// encodings, boolean constants and the default ROB tag width.
package alu_rs_pkg;

    localparam int unsigned ALU_RS_TAG_W = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_MINUS = 4'd1,
        ALU_OR    = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_AND   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_LT    = 4'd8,
        ALU_LTU   = 4'd9,
        ALU_EQ    = 4'd10,
        ALU_NE    = 4'd11,
        ALU_GE    = 4'd12,
        ALU_GEU   = 4'd13
    } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue bundle of the ALU reservation station.
// The slave modport is the station; the master modport is its environment.
interface alu_rs_if
    import alu_rs_pkg::*;
#(
    parameter int unsigned TAG_W = ALU_RS_TAG_W
) ();

    logic             rdy;
    logic             flush;

    logic             disp_valid;
    logic [3:0]       disp_op;
    logic [31:0]      disp_vj;
    logic [31:0]      disp_vk;
    logic             disp_qj_valid;
    logic             disp_qk_valid;
    logic [TAG_W-1:0] disp_qj;
    logic [TAG_W-1:0] disp_qk;
    logic [TAG_W-1:0] disp_dest;
    logic             full;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    logic             alu_ready;
    logic [31:0]      alu_lv;
    logic [31:0]      alu_rv;
    logic [3:0]       alu_op;
    logic [TAG_W-1:0] alu_dest;

    modport slave (
        input  rdy, flush,
        input  disp_valid, disp_op, disp_vj, disp_vk,
        input  disp_qj_valid, disp_qk_valid, disp_qj, disp_qk, disp_dest,
        output full,
        input  cdb_valid, cdb_tag, cdb_value,
        output alu_ready, alu_lv, alu_rv, alu_op, alu_dest
    );

    modport master (
        output rdy, flush,
        output disp_valid, disp_op, disp_vj, disp_vk,
        output disp_qj_valid, disp_qk_valid, disp_qj, disp_qk, disp_dest,
        input  full,
        output cdb_valid, cdb_tag, cdb_value,
        input  alu_ready, alu_lv, alu_rv, alu_op, alu_dest
    );

endinterface

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest set bit.
module alu_rs_select #(
    parameter  int unsigned ENTRIES = 8,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] req,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (req[i-1]) begin
                found = 1'b1;
                idx   = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station. Holds dispatched ops until both operands
// are ready, snoops the CDB for pending operands, and issues at most one
// ready entry per cycle as registered inputs to the combinational ALU.
// Optional feature: define ALU_RS_CDB_FORWARD_EN to let select treat an
// operand matching the current CDB broadcast as ready, issuing one cycle
// earlier with cdb_value substituted.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned TAG_W   = ALU_RS_TAG_W
) (
    input  logic     clk,
    input  logic     rst,
    alu_rs_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] qj_valid;
    logic [ENTRIES-1:0] qk_valid;
    logic [3:0]         op   [ENTRIES];
    logic [31:0]        vj   [ENTRIES];
    logic [31:0]        vk   [ENTRIES];
    logic [TAG_W-1:0]   qj   [ENTRIES];
    logic [TAG_W-1:0]   qk   [ENTRIES];
    logic [TAG_W-1:0]   dest [ENTRIES];

    logic [ENTRIES-1:0] j_hit;
    logic [ENTRIES-1:0] k_hit;
    logic [ENTRIES-1:0] ready_vec;
    logic               full;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;
    logic [31:0]        issue_lv;
    logic [31:0]        issue_rv;
    logic               disp_j_hit;
    logic               disp_k_hit;

    assign full     = &valid;
    assign bus.full = full;

    alu_rs_select #(.ENTRIES(ENTRIES)) u_free_sel (
        .req   (~valid),
        .found (free_found),
        .idx   (free_idx)
    );

    alu_rs_select #(.ENTRIES(ENTRIES)) u_issue_sel (
        .req   (ready_vec),
        .found (issue_found),
        .idx   (issue_idx)
    );

    // CDB tag match per stored operand, and readiness of each entry for select.
    always_comb begin
        j_hit     = '0;
        k_hit     = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            j_hit[i] = valid[i] && qj_valid[i] && bus.cdb_valid && (qj[i] == bus.cdb_tag);
            k_hit[i] = valid[i] && qk_valid[i] && bus.cdb_valid && (qk[i] == bus.cdb_tag);
`ifdef ALU_RS_CDB_FORWARD_EN
            ready_vec[i] = valid[i] && (!qj_valid[i] || j_hit[i]) && (!qk_valid[i] || k_hit[i]);
`else
            ready_vec[i] = valid[i] && !qj_valid[i] && !qk_valid[i];
`endif
        end
    end

    // Operand values presented to the ALU for the selected entry.
    always_comb begin
        issue_lv = vj[issue_idx];
        issue_rv = vk[issue_idx];
`ifdef ALU_RS_CDB_FORWARD_EN
        // A still-pending operand can only be selected via a CDB match.
        if (qj_valid[issue_idx]) issue_lv = bus.cdb_value;
        if (qk_valid[issue_idx]) issue_rv = bus.cdb_value;
`endif
    end

    // Same-cycle capture of a dispatched operand being broadcast right now.
    always_comb begin
        disp_j_hit = bus.disp_qj_valid && bus.cdb_valid && (bus.disp_qj == bus.cdb_tag);
        disp_k_hit = bus.disp_qk_valid && bus.cdb_valid && (bus.disp_qk == bus.cdb_tag);
    end

    // Station state and registered ALU outputs: clear, wakeup, issue, dispatch.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid         <= '0;
            bus.alu_ready <= FALSE;
            bus.alu_lv    <= '0;
            bus.alu_rv    <= '0;
            bus.alu_op    <= '0;
            bus.alu_dest  <= '0;
        end else if (bus.rdy) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (j_hit[i]) begin
                    vj[i]       <= bus.cdb_value;
                    qj_valid[i] <= FALSE;
                end
                if (k_hit[i]) begin
                    vk[i]       <= bus.cdb_value;
                    qk_valid[i] <= FALSE;
                end
            end

            bus.alu_ready <= issue_found;
            if (issue_found) begin
                valid[issue_idx] <= FALSE;
                bus.alu_lv       <= issue_lv;
                bus.alu_rv       <= issue_rv;
                bus.alu_op       <= op[issue_idx];
                bus.alu_dest     <= dest[issue_idx];
            end

            assert (!(bus.disp_valid && full))
                else $warning("alu_rs: dispatch while full dropped");

            // The free slot is invalid in stored state, so it never collides
            // with the issuing entry and cannot itself issue this cycle.
            if (bus.disp_valid && free_found) begin
                valid[free_idx]    <= TRUE;
                op[free_idx]       <= bus.disp_op;
                dest[free_idx]     <= bus.disp_dest;
                qj[free_idx]       <= bus.disp_qj;
                qk[free_idx]       <= bus.disp_qk;
                vj[free_idx]       <= disp_j_hit ? bus.cdb_value : bus.disp_vj;
                vk[free_idx]       <= disp_k_hit ? bus.cdb_value : bus.disp_vk;
                qj_valid[free_idx] <= bus.disp_qj_valid && !disp_j_hit;
                qk_valid[free_idx] <= bus.disp_qk_valid && !disp_k_hit;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios followed by random
// traffic, all scored against a behavioural model of the station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_rs_if #(.TAG_W(4)) bus ();

    alu_rs #(.ENTRIES(N), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned edge_n;
        logic [31:0] lv;
        logic [31:0] rv;
        logic [3:0]  op;
        logic [3:0]  dest;
    } exp_t;

    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        bit          pj;
        bit          pk;
        logic [3:0]  tj;
        logic [3:0]  tk;
        logic [3:0]  dest;
    } ent_t;

    exp_t        sb[$];
    ent_t        m[N];
    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;
    int unsigned edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_full();
        foreach (m[i]) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the reference station, from the inputs on the bus.
    function automatic void model_edge();
        int   sel  = -1;
        int   slot = -1;
        bit   jr, kr;
        exp_t e;
        if (rst || bus.flush) begin
            foreach (m[i]) m[i].v = 1'b0;
            return;
        end
        if (!bus.rdy) return;
        foreach (m[i]) begin
            jr = !m[i].pj;
            kr = !m[i].pk;
`ifdef ALU_RS_CDB_FORWARD_EN
            jr = jr || (bus.cdb_valid && m[i].tj == bus.cdb_tag);
            kr = kr || (bus.cdb_valid && m[i].tk == bus.cdb_tag);
`endif
            if (sel < 0 && m[i].v && jr && kr) sel = i;
            if (slot < 0 && !m[i].v) slot = i;
        end
        if (sel >= 0) begin
            e.edge_n = edge_n;
            e.lv     = m[sel].pj ? bus.cdb_value : m[sel].vj;
            e.rv     = m[sel].pk ? bus.cdb_value : m[sel].vk;
            e.op     = m[sel].op;
            e.dest   = m[sel].dest;
            sb.push_back(e);
        end
        if (bus.cdb_valid) begin
            foreach (m[i]) begin
                if (m[i].v && m[i].pj && m[i].tj == bus.cdb_tag) begin m[i].vj = bus.cdb_value; m[i].pj = 0; end
                if (m[i].v && m[i].pk && m[i].tk == bus.cdb_tag) begin m[i].vk = bus.cdb_value; m[i].pk = 0; end
            end
        end
        if (sel >= 0) m[sel].v = 1'b0;
        if (bus.disp_valid && slot >= 0) begin
            m[slot].v    = 1'b1;
            m[slot].op   = bus.disp_op;
            m[slot].dest = bus.disp_dest;
            m[slot].tj   = bus.disp_qj;
            m[slot].tk   = bus.disp_qk;
            m[slot].pj   = bus.disp_qj_valid;
            m[slot].pk   = bus.disp_qk_valid;
            m[slot].vj   = bus.disp_vj;
            m[slot].vk   = bus.disp_vk;
            if (m[slot].pj && bus.cdb_valid && m[slot].tj == bus.cdb_tag) begin m[slot].vj = bus.cdb_value; m[slot].pj = 0; end
            if (m[slot].pk && bus.cdb_valid && m[slot].tk == bus.cdb_tag) begin m[slot].vk = bus.cdb_value; m[slot].pk = 0; end
        end
    endfunction

    // Every posedge goes through here so the driver and monitor edge counts agree.
    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check("full", 32'(bus.full), 32'(model_full()));
        @(negedge clk);
        bus.disp_valid    = 1'b0;
        bus.disp_qj_valid = 1'b0;
        bus.disp_qk_valid = 1'b0;
        bus.cdb_valid     = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input bit pj, input logic [3:0] tj, input bit pk, input logic [3:0] tk,
                        input logic [3:0] dest);
        bus.disp_valid    = 1'b1;
        bus.disp_op       = op;
        bus.disp_vj       = vj;
        bus.disp_vk       = vk;
        bus.disp_qj_valid = pj;
        bus.disp_qj       = tj;
        bus.disp_qk_valid = pk;
        bus.disp_qk       = tk;
        bus.disp_dest     = dest;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    // Monitor: pops the expected issue for each updating edge and compares.
    initial begin
        int unsigned me;
        bit          upd;
        bit          clr;
        exp_t        e;
        me = 0;
        forever begin
            @(posedge clk);
            me++;
            clr = rst || bus.flush;
            upd = bus.rdy && !clr;
            #1;
            if (clr) begin
                check("clear_alu_ready", 32'(bus.alu_ready), 32'(0));
            end else if (upd) begin
                if (sb.size() > 0 && sb[0].edge_n == me) begin
                    e = sb.pop_front();
                    check("issue_ready", 32'(bus.alu_ready), 32'(1));
                    check("issue_lv",    bus.alu_lv,         e.lv);
                    check("issue_rv",    bus.alu_rv,         e.rv);
                    check("issue_op",    32'(bus.alu_op),    32'(e.op));
                    check("issue_dest",  32'(bus.alu_dest),  32'(e.dest));
                end else begin
                    check("idle_ready", 32'(bus.alu_ready), 32'(0));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_op = '0;
        bus.disp_vj = '0;
        bus.disp_vk = '0;
        bus.disp_qj_valid = 1'b0;
        bus.disp_qk_valid = 1'b0;
        bus.disp_qj = '0;
        bus.disp_qk = '0;
        bus.disp_dest = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_value = '0;

        // Reset held two cycles with a dispatch that must be ignored.
        disp(ALU_ADD, 32'd1, 32'd2, 0, 4'd0, 0, 4'd0, 4'd1);
        step();
        disp(ALU_ADD, 32'd1, 32'd2, 0, 4'd0, 0, 4'd0, 4'd1);
        step();
        check("rst_alu_ready", 32'(bus.alu_ready), 32'(0));
        check("rst_full",      32'(bus.full),      32'(0));
        check("rst_alu_lv",    bus.alu_lv,         32'(0));
        check("rst_alu_rv",    bus.alu_rv,         32'(0));
        check("rst_alu_op",    32'(bus.alu_op),    32'(0));
        check("rst_alu_dest",  32'(bus.alu_dest),  32'(0));
        rst = 1'b0;
        step();

        // Ready dispatch: issues on the next edge.
        disp(ALU_ADD, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 4'd3);
        step();
        step();
        check("ready_alu_ready", 32'(bus.alu_ready), 32'(1));
        check("ready_alu_sum",   bus.alu_lv + bus.alu_rv, 32'd12);
        check("ready_alu_dest",  32'(bus.alu_dest), 32'(3));

        // Wakeup through the CDB.
        disp(ALU_MINUS, 32'd0, 32'd1, 1, 4'd2, 0, 4'd0, 4'd4);
        step();
        step();
        step();
        cdb(4'd2, 32'd10);
        step();
        step();
        step();

        // Same-cycle dispatch and broadcast of the pending operand.
        disp(ALU_AND, 32'd3, 32'd0, 0, 4'd0, 1, 4'd5, 4'd6);
        cdb(4'd5, 32'hFFFF_FFFF);
        step();
        step();
        step();

        // Fill all entries waiting on tag 9, then overflow one more.
        for (int i = 0; i < N; i++) begin
            disp(ALU_OR, 32'd0, 32'(i), 1, 4'd9, 0, 4'd0, 4'(i));
            step();
        end
        check("fill_full", 32'(bus.full), 32'(1));
        disp(ALU_XOR, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 4'd15);
        step();
        cdb(4'd9, 32'h99);
        step();
        for (int i = 0; i < 10; i++) step();

        // Stall with pending entries, then flush.
        for (int i = 0; i < 4; i++) begin
            disp(ALU_SLL, 32'd0, 32'(i), 1, 4'd11, 0, 4'd0, 4'(i + 8));
            step();
        end
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cdb(4'd11, 32'h1111);
            disp(ALU_ADD, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 4'd1);
            step();
        end
        bus.rdy = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush_full", 32'(bus.full), 32'(0));
        cdb(4'd11, 32'h2222);
        step();
        for (int i = 0; i < 3; i++) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.rdy = ($urandom_range(9) != 0);
            if (bus.rdy && $urandom_range(49) == 0) bus.flush = 1'b1;
            if ($urandom_range(1) == 1 && (!model_full() || $urandom_range(15) == 0)) begin
                disp(4'($urandom_range(13)), $urandom, $urandom,
                     1'($urandom_range(1)), 4'($urandom_range(15)),
                     1'($urandom_range(1)), 4'($urandom_range(15)),
                     4'($urandom_range(15)));
            end
            if ($urandom_range(9) < 4) cdb(4'($urandom_range(15)), $urandom);
            step();
        end

        // Drain: broadcast every tag once so all remaining entries become ready.
        bus.rdy = 1'b1;
        for (int t = 0; t < 16; t++) begin
            cdb(4'(t), $urandom);
            step();
        end
        for (int i = 0; i < 12; i++) step();
        check("station_drained", 32'(model_full()) | 32'(bus.full), 32'(0));
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
